// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// The entry struct is width-parametrised, so each module declares it locally from its own DATA_W/RD_W.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int RD_W_DEF   = 5;
    localparam int DATA_W_DEF = 64;
    localparam int ZERO_REG   = 0;

    function automatic logic [1:0] state_count(state_e s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake, lookup and occupancy signals of pipe_stage_buf.
// Signal suffixes are named from the stage's point of view.
interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic              in_wb_en_i;
    logic [RD_W-1:0]   in_rd_addr_i;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_wb_en_o;
    logic [RD_W-1:0]   out_rd_addr_o;
    logic [DATA_W-1:0] out_data_o;
    logic [RD_W-1:0]   lookup_addr_i;
    logic              lookup_hit_o;
    logic [DATA_W-1:0] lookup_data_o;
    logic [1:0]        count_o;

    modport slave (
        input  in_valid_i, in_wb_en_i, in_rd_addr_i, in_data_i, out_ready_i, lookup_addr_i,
        output in_ready_o, out_valid_o, out_wb_en_o, out_rd_addr_o, out_data_o,
               lookup_hit_o, lookup_data_o, count_o
    );

    modport master (
        output in_valid_i, in_wb_en_i, in_rd_addr_i, in_data_i, out_ready_i, lookup_addr_i,
        input  in_ready_o, out_valid_o, out_wb_en_o, out_rd_addr_o, out_data_o,
               lookup_hit_o, lookup_data_o, count_o
    );

endinterface

// File: rtl/pipe_entry_reg.sv
// One held beat: payload loaded on i_load, valid bit with clear-over-set priority.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_load,
    input  logic              i_vld_set,
    input  logic              i_vld_clr,
    input  logic              i_wb_en,
    input  logic [RD_W-1:0]   i_rd_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_wb_en,
    output logic [RD_W-1:0]   o_rd_addr,
    output logic [DATA_W-1:0] o_data
);
    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic [RD_W-1:0]   rd_addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t r_entry;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_entry <= '0;
        end else begin
            if (i_vld_clr)      r_entry.valid <= 1'b0;
            else if (i_vld_set) r_entry.valid <= 1'b1;
            if (i_load) begin
                r_entry.wb_en   <= i_wb_en;
                r_entry.rd_addr <= i_rd_addr;
                r_entry.data    <= i_data;
            end
        end
    end

    assign o_valid   = r_entry.valid;
    assign o_wb_en   = r_entry.wb_en;
    assign o_rd_addr = r_entry.rd_addr;
    assign o_data    = r_entry.data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: main + skid entry, valid/ready handshake, flush, run enable,
// and a combinational pending-write lookup for hazard/forwarding logic.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             flush_i,
    pipe_stage_buf_if.slave  bus
);
    state_e r_state, w_state_nxt;

    logic              w_in_fire, w_out_fire;
    logic              w_main_load, w_main_from_skid, w_skid_load;
    logic              w_main_vld, w_main_wb, w_skid_vld, w_skid_wb;
    logic [RD_W-1:0]   w_main_rd, w_skid_rd, w_main_rd_d;
    logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_data_d;
    logic              w_main_wb_d;
    logic              w_main_hit, w_skid_hit;

    // in_ready comes from registered state only, so out_ready never reaches it combinationally
    assign bus.in_ready_o  = start_i & (r_state != FULL);
    assign bus.out_valid_o = start_i & w_main_vld;
    assign w_in_fire       = bus.in_valid_i & bus.in_ready_o;
    assign w_out_fire      = bus.out_valid_o & bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= EMPTY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush_i) begin
            w_state_nxt = EMPTY;
        end else if (start_i) begin
            case (r_state)
                EMPTY: if (w_in_fire) begin
                    w_state_nxt = ONE;
                    w_main_load = 1'b1;
                end
                ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        w_state_nxt = FULL;
                        w_skid_load = 1'b1;
                    end else if (!w_in_fire && w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end else if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end
                end
                FULL: if (w_out_fire) begin
                    w_state_nxt      = ONE;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    assign w_main_wb_d   = w_main_from_skid ? w_skid_wb   : bus.in_wb_en_i;
    assign w_main_rd_d   = w_main_from_skid ? w_skid_rd   : bus.in_rd_addr_i;
    assign w_main_data_d = w_main_from_skid ? w_skid_data : bus.in_data_i;

    pipe_entry_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) u_main (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_load    (w_main_load),
        .i_vld_set (w_state_nxt != EMPTY),
        .i_vld_clr (w_state_nxt == EMPTY),
        .i_wb_en   (w_main_wb_d),
        .i_rd_addr (w_main_rd_d),
        .i_data    (w_main_data_d),
        .o_valid   (w_main_vld),
        .o_wb_en   (w_main_wb),
        .o_rd_addr (w_main_rd),
        .o_data    (w_main_data)
    );

    pipe_entry_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_load    (w_skid_load),
        .i_vld_set (w_state_nxt == FULL),
        .i_vld_clr (w_state_nxt != FULL),
        .i_wb_en   (bus.in_wb_en_i),
        .i_rd_addr (bus.in_rd_addr_i),
        .i_data    (bus.in_data_i),
        .o_valid   (w_skid_vld),
        .o_wb_en   (w_skid_wb),
        .o_rd_addr (w_skid_rd),
        .o_data    (w_skid_data)
    );

    assign bus.out_wb_en_o   = w_main_wb & bus.out_valid_o;
    assign bus.out_rd_addr_o = w_main_rd;
    assign bus.out_data_o    = w_main_data;
    assign bus.count_o       = state_count(r_state);

    // x0 is hard-wired zero, so it can never be a pending write
    assign w_main_hit = w_main_vld & w_main_wb & (w_main_rd == bus.lookup_addr_i)
                      & (bus.lookup_addr_i != RD_W'(ZERO_REG));
    assign w_skid_hit = w_skid_vld & w_skid_wb & (w_skid_rd == bus.lookup_addr_i)
                      & (bus.lookup_addr_i != RD_W'(ZERO_REG));

    assign bus.lookup_hit_o  = w_main_hit | w_skid_hit;
    assign bus.lookup_data_o = w_skid_hit ? w_skid_data :
                               w_main_hit ? w_main_data : '0;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized + directed bench for pipe_stage_buf; a queue-based model tracks held beats
// and a negedge monitor compares every DUT output against it.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int DW = 64;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic flush = 1'b0;

    pipe_stage_buf_if #(.DATA_W(DW), .RD_W(RW)) bus ();

    pipe_stage_buf #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wb;
        logic [RW-1:0] rd;
        logic [DW-1:0] d;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2 gated by start, emptied by flush/reset.
    always @(posedge clk or negedge rst_n) begin : model
        int n;
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else if (start) begin
            n = exp_q.size();
            if (n > 0 && bus.out_ready_i)
                void'(exp_q.pop_front());
            if (bus.in_valid_i && n < 2)
                exp_q.push_back('{bus.in_wb_en_i, bus.in_rd_addr_i, bus.in_data_i});
        end
    end

    logic          m_hit;
    logic [DW-1:0] m_ldat;
    int            m_n;

    always @(negedge clk) begin
        if (rst_n) begin
            m_n = exp_q.size();
            chk("count", 64'(bus.count_o), 64'(m_n));
            chk("in_ready", 64'(bus.in_ready_o), 64'(start && m_n < 2));
            chk("out_valid", 64'(bus.out_valid_o), 64'(start && m_n > 0));
            if (start && m_n > 0) begin
                chk("out_wb_en", 64'(bus.out_wb_en_o), 64'(exp_q[0].wb));
                chk("out_rd", 64'(bus.out_rd_addr_o), 64'(exp_q[0].rd));
                chk("out_data", bus.out_data_o, exp_q[0].d);
            end else begin
                chk("out_wb_en_idle", 64'(bus.out_wb_en_o), 64'd0);
            end
            m_hit  = 1'b0;
            m_ldat = '0;
            for (int i = 0; i < m_n; i++) begin
                if (exp_q[i].wb && exp_q[i].rd == bus.lookup_addr_i && bus.lookup_addr_i != 0) begin
                    m_hit  = 1'b1;
                    m_ldat = exp_q[i].d;
                end
            end
            chk("lookup_hit", 64'(bus.lookup_hit_o), 64'(m_hit));
            chk("lookup_data", bus.lookup_data_o, m_ldat);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic wb, input logic [RW-1:0] rd, input logic [DW-1:0] d);
        bus.in_valid_i   = v;
        bus.in_wb_en_i   = wb;
        bus.in_rd_addr_i = rd;
        bus.in_data_i    = d;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
        chk({tag, "_out_wb_en"}, 64'(bus.out_wb_en_o), 64'd0);
        chk({tag, "_out_rd"}, 64'(bus.out_rd_addr_o), 64'd0);
        chk({tag, "_out_data"}, bus.out_data_o, 64'd0);
        chk({tag, "_count"}, 64'(bus.count_o), 64'd0);
        chk({tag, "_lookup_hit"}, 64'(bus.lookup_hit_o), 64'd0);
        chk({tag, "_lookup_data"}, bus.lookup_data_o, 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'(start));
    endtask

    initial begin
        set_beat(1'b0, 1'b0, '0, '0);
        bus.out_ready_i   = 1'b0;
        bus.lookup_addr_i = 5'd5;
        #12;
        chk_reset_outs("rst");
        start = 1'b1;
        #1;
        chk("rst_in_ready_start", 64'(bus.in_ready_o), 64'd1);
        #2;
        rst_n = 1'b1;

        // single beat, 1-edge latency
        step();
        set_beat(1'b1, 1'b1, 5'd5, 64'hA);
        bus.out_ready_i = 1'b1;
        step();
        set_beat(1'b0, 1'b0, '0, '0);
        chk("t1_valid", 64'(bus.out_valid_o), 64'd1);
        chk("t1_rd", 64'(bus.out_rd_addr_o), 64'd5);
        chk("t1_data", bus.out_data_o, 64'hA);
        chk("t1_count", 64'(bus.count_o), 64'd1);
        chk("t1_hit", 64'(bus.lookup_hit_o), 64'd1);
        step();

        // backpressure fills skid, then drains in order
        bus.out_ready_i = 1'b0;
        set_beat(1'b1, 1'b1, 5'd7, 64'h100);
        step();
        set_beat(1'b1, 1'b0, 5'd8, 64'h200);
        step();
        set_beat(1'b0, 1'b0, '0, '0);
        chk("bp_count", 64'(bus.count_o), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
        bus.out_ready_i = 1'b1;
        #1;
        chk("bp_first", bus.out_data_o, 64'h100);
        step();
        chk("bp_second", bus.out_data_o, 64'h200);
        chk("bp_second_wb", 64'(bus.out_wb_en_o), 64'd0);
        step();
        chk("bp_drained", 64'(bus.count_o), 64'd0);

        // youngest match wins on lookup
        bus.out_ready_i = 1'b0;
        set_beat(1'b1, 1'b1, 5'd3, 64'h11);
        step();
        set_beat(1'b1, 1'b1, 5'd3, 64'h22);
        step();
        bus.lookup_addr_i = 5'd3;
        #1;
        chk("lk_hit", 64'(bus.lookup_hit_o), 64'd1);
        chk("lk_young", bus.lookup_data_o, 64'h22);

        // flush while FULL with a pending upstream beat
        set_beat(1'b1, 1'b1, 5'd9, 64'hDEAD);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_beat(1'b0, 1'b0, '0, '0);
        chk("fl_count", 64'(bus.count_o), 64'd0);
        chk("fl_valid", 64'(bus.out_valid_o), 64'd0);

        // x0 never hits
        set_beat(1'b1, 1'b1, 5'd0, 64'h33);
        step();
        set_beat(1'b0, 1'b0, '0, '0);
        bus.lookup_addr_i = 5'd0;
        #1;
        chk("x0_hit", 64'(bus.lookup_hit_o), 64'd0);
        chk("x0_data", bus.lookup_data_o, 64'd0);

        // flush concurrent with an in_fire from ONE
        set_beat(1'b1, 1'b1, 5'd4, 64'hBEEF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_beat(1'b0, 1'b0, '0, '0);
        chk("fl1_count", 64'(bus.count_o), 64'd0);

        // start low freezes the stage
        set_beat(1'b1, 1'b1, 5'd6, 64'h66);
        step();
        set_beat(1'b1, 1'b1, 5'd1, 64'h77);
        bus.out_ready_i = 1'b1;
        start = 1'b0;
        bus.lookup_addr_i = 5'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_valid", 64'(bus.out_valid_o), 64'd0);
            chk("st_ready", 64'(bus.in_ready_o), 64'd0);
            chk("st_count", 64'(bus.count_o), 64'd1);
            chk("st_lookup", bus.lookup_data_o, 64'h66);
        end
        set_beat(1'b0, 1'b0, '0, '0);
        start = 1'b1;
        #1;
        chk("st_resume", bus.out_data_o, 64'h66);
        step();

        // async reset between edges while holding beats
        bus.out_ready_i = 1'b0;
        set_beat(1'b1, 1'b1, 5'd2, 64'h55);
        step();
        set_beat(1'b1, 1'b1, 5'd2, 64'h56);
        step();
        set_beat(1'b0, 1'b0, '0, '0);
        bus.lookup_addr_i = 5'd2;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("arst");
        #4;
        rst_n = 1'b1;
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            set_beat($urandom_range(0, 9) < 7, 1'($urandom), RW'($urandom_range(0, 7)),
                     {$urandom, $urandom});
            bus.out_ready_i   = ($urandom_range(0, 9) < 6);
            bus.lookup_addr_i = RW'($urandom_range(0, 7));
            step();
        end

        flush = 1'b0;
        set_beat(1'b0, 1'b0, '0, '0);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
